sensor_reader: RTL and testbench
================================

// Module: sensor_reader
// PURPOSE
//  Input-side counterpart to the valve pulse drivers: conditions one asynchronous
//  rig sensor (lick/IR beam), debounces it and qualifies high pulses by min width.
//  Emits a 1-cycle event strobe and a saturating event count.
//  Hands each qualified pulse width to the host-interface logic via valid/ack.
// PARAMETERS
//  SYNC_STAGES  2   flops in the input synchronizer chain (>=2)
//  TIME_W       24  width of debounce/min-width/measured-width counters
//  COUNT_W      16  width of event_count
// PORTS
//  clk              in   1        system clock
//  reset_n          in   1        synchronous, active-low reset
//  sensor_in        in   1        raw asynchronous sensor line, active high
//  arm              in   1        level; 1 = detection enabled
//  clear_count      in   1        1-cycle strobe; zeroes event_count
//  debounce_cycles  in   TIME_W   stable cycles required to accept a level change
//  min_width        in   TIME_W   debounced-high cycles required to qualify a pulse
//  sensor_level     out  1        debounced level
//  event_pulse      out  1        1-cycle strobe on qualification
//  event_count      out  COUNT_W  qualified events since reset/clear, saturating
//  last_width       out  TIME_W   high duration of last qualified pulse, cycles
//  width_valid      out  1        last_width holds an unacknowledged value
//  width_ack        in   1        consumer accepts last_width
//  width_overrun    out  1        sticky: width latched while width_valid was 1
// BEHAVIOUR
//  Reset: all outputs 0, sync chain 0, stable level 0, FSM S_IDLE.
//  Sync: sensor_in passes SYNC_STAGES flops -> s_sync. No logic on raw input.
//  Debounce: if s_sync==sensor_level, db_cnt<=0. Else if db_cnt==debounce_cycles:
//   sensor_level<=s_sync, db_cnt<=0. Else db_cnt++. A change needs
//   debounce_cycles+1 consecutive mismatched cycles. debounce_cycles=0 -> 1 cycle.
//   A glitch shorter than that never changes sensor_level.
//  FSM (driven by sensor_level, a registered signal):
//   S_IDLE:    arm=1 & level=0 -> S_WAIT. arm=1 & level=1 stays here:
//              a stuck-high sensor is never counted.
//   S_WAIT:    level=1 -> S_MEASURE, width<=1, qual<=0.
//   S_MEASURE: level=1 -> width<=width+1, saturating at all-ones.
//              Same edge, if !qual & width>=min_width: qual<=1, event_pulse<=1,
//              event_count++ (saturating).
//              level=0 -> if qual: last_width<=width, width_valid<=1.
//              Always -> S_WAIT. Unqualified pulses are discarded silently.
//   arm=0 in any state -> S_IDLE next cycle. An in-flight pulse is discarded.
//   event_count, last_width and width_valid are kept.
//  min_width=0 or 1: qualifies on the first S_MEASURE cycle.
//  event_pulse is exactly 1 cycle. Max one event per debounced high pulse.
//  clear_count together with a qualification: the count ends at 1 (increment wins).
//  Handshake: width_ack with width_valid=1 clears width_valid.
//   A new latch on the same cycle as ack: width_valid stays 1, new value held.
//   A new latch while width_valid=1 and no ack: overwrite, width_overrun<=1.
//   Only reset clears width_overrun. width_ack with width_valid=0 is ignored.
//  Config ports are sampled live. Change them only while arm=0.
//  reset_n low mid-pulse: everything returns to reset values on that edge.
// STRUCTURE
//  Shared package: FSM state encodings (2-bit S_IDLE/S_WAIT/S_MEASURE) and
//  TIME_W/COUNT_W defaults, shared with the valve pulse drivers.
//  Sub-module: input_debouncer (synchronizer + db_cnt -> sensor_level).
//  The top holds the FSM, the counters and the handshake.
// TESTING
//  1 debounce=3, min=10, arm=1; sensor_in high for 3 clks -> sensor_level never rises,
//    event_count=0.
//  2 debounce=3, min=10; sensor_in high 50 clks -> one event_pulse, event_count=1;
//    last_width=50, width_valid=1; width_ack -> width_valid=0.
//  3 min=100; pulse of 40 clks -> no event_pulse, width_valid stays 0.
//    Then a pulse of 120 clks -> event_count=1, last_width=120.
//  4 Two qualified pulses (30, 60 clks), no ack, min=10 -> width_valid=1,
//    last_width=60, width_overrun=1. Ack and next latch on the same cycle -> valid stays 1.
//  5 sensor_in high before arm rises -> no event until a low then a high.
//    Drop arm mid-pulse -> pulse discarded, count unchanged.
//  6 Preload event_count=16'hFFFF via 65535 pulses, or force in sim:
//    1 more pulse -> stays 16'hFFFF. clear_count -> 0.
//    reset_n=0 mid-pulse -> all outputs 0 next edge.

Source files
------------

// File: rtl/sensor_reader_pkg.sv
// Purpose: shared definitions for the rig sensor reader and the valve pulse drivers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sensor_reader_pkg;

    // Default widths, shared with the valve pulse drivers so that the time bases match.
    localparam int SYNC_STAGES_DEF = 2;
    localparam int TIME_W_DEF      = 24;
    localparam int COUNT_W_DEF     = 16;

    // Pulse-qualification state machine encoding.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_MEASURE = 2'd2
    } rd_state_e;

endpackage

// File: rtl/sensor_reader_input_debouncer.sv
// Purpose: synchronizes one raw asynchronous line and debounces it into a stable level.
// Latency: SYNC_STAGES + debounce_cycles + 1 cycles from a raw edge to sensor_level.
// Backpressure: none; free-running, the level is always valid.
// Ports: clk, reset_n (sync, active low), sensor_in (raw line), debounce_cycles (live
//        config), sensor_level (debounced, registered).
module sensor_reader_input_debouncer
    import sensor_reader_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int TIME_W      = TIME_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sensor_in,
    input  logic [TIME_W-1:0] debounce_cycles,
    output logic              sensor_level
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [TIME_W-1:0]      db_cnt_q;
    logic [TIME_W-1:0]      db_cnt_d;
    logic                   level_q;
    logic                   level_d;
    logic                   s_sync;

    // The raw line only ever feeds the first flop of the chain.
    assign s_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], sensor_in};
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        if (s_sync == level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == debounce_cycles) begin
            // debounce_cycles+1 consecutive mismatched cycles seen: accept the change.
            level_d  = s_sync;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + TIME_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q   <= '0;
            db_cnt_q <= '0;
            level_q  <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            db_cnt_q <= db_cnt_d;
            level_q  <= level_d;
        end
    end

    assign sensor_level = level_q;

endmodule

// File: rtl/sensor_reader.sv
// Purpose: debounced rig-sensor pulse qualifier with event strobe, saturating count and width hand-off.
// Latency: event_pulse one cycle after the qualifying level cycle; last_width one cycle after level falls.
// Backpressure: width_valid/width_ack; an unacknowledged width is overwritten and width_overrun set.
// Ports: clk, reset_n (sync, active low), sensor_in, arm, clear_count, debounce_cycles,
//        min_width, sensor_level, event_pulse, event_count, last_width, width_valid,
//        width_ack, width_overrun.
module sensor_reader
    import sensor_reader_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int TIME_W      = TIME_W_DEF,
    parameter int COUNT_W     = COUNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sensor_in,
    input  logic               arm,
    input  logic               clear_count,
    input  logic [TIME_W-1:0]  debounce_cycles,
    input  logic [TIME_W-1:0]  min_width,
    output logic               sensor_level,
    output logic               event_pulse,
    output logic [COUNT_W-1:0] event_count,
    output logic [TIME_W-1:0]  last_width,
    output logic               width_valid,
    input  logic               width_ack,
    output logic               width_overrun
);

    localparam logic [TIME_W-1:0]  WIDTH_MAX = '1;
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    rd_state_e          state_q;
    rd_state_e          state_d;
    logic [TIME_W-1:0]  width_q;
    logic [TIME_W-1:0]  width_d;
    logic               qual_q;
    logic               qual_d;
    logic               event_pulse_q;
    logic               event_pulse_d;
    logic [COUNT_W-1:0] event_count_q;
    logic [COUNT_W-1:0] event_count_d;
    logic [TIME_W-1:0]  last_width_q;
    logic [TIME_W-1:0]  last_width_d;
    logic               width_valid_q;
    logic               width_valid_d;
    logic               width_overrun_q;
    logic               width_overrun_d;

    logic               level;
    logic               qualify;
    logic               latch;

    sensor_reader_input_debouncer #(
        .SYNC_STAGES (SYNC_STAGES),
        .TIME_W      (TIME_W)
    ) u_debouncer (
        .clk             (clk),
        .reset_n         (reset_n),
        .sensor_in       (sensor_in),
        .debounce_cycles (debounce_cycles),
        .sensor_level    (level)
    );

    // Pulse state machine: only ever looks at the registered debounced level.
    always_comb begin
        state_d = state_q;
        width_d = width_q;
        qual_d  = qual_q;
        qualify = 1'b0;
        latch   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A sensor already high when armed must go low first; never counted.
                if (arm && !level) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (level) begin
                    state_d = S_MEASURE;
                    width_d = TIME_W'(1);
                    qual_d  = 1'b0;
                end
            end
            S_MEASURE: begin
                if (level) begin
                    width_d = (width_q == WIDTH_MAX) ? width_q : width_q + TIME_W'(1);
                    // Compares the pre-increment width, so min_width 0 and 1 both
                    // qualify on the first measuring cycle.
                    if (!qual_q && (width_q >= min_width)) begin
                        qual_d  = 1'b1;
                        qualify = 1'b1;
                    end
                end else begin
                    latch   = qual_q;
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Disarming overrides everything: an in-flight pulse neither counts nor latches.
        if (!arm) begin
            state_d = S_IDLE;
            qual_d  = 1'b0;
            qualify = 1'b0;
            latch   = 1'b0;
        end
    end

    // Event strobe and saturating counter; an increment beats a simultaneous clear.
    always_comb begin
        event_pulse_d = qualify;
        event_count_d = event_count_q;
        if (qualify && clear_count) begin
            event_count_d = COUNT_W'(1);
        end else if (qualify) begin
            event_count_d = (event_count_q == COUNT_MAX) ? event_count_q
                                                         : event_count_q + COUNT_W'(1);
        end else if (clear_count) begin
            event_count_d = '0;
        end
    end

    // Width hand-off: a latch always wins over an ack on the same cycle.
    always_comb begin
        last_width_d    = last_width_q;
        width_valid_d   = width_valid_q;
        width_overrun_d = width_overrun_q;
        if (latch) begin
            last_width_d  = width_q;
            width_valid_d = 1'b1;
            if (width_valid_q && !width_ack) begin
                width_overrun_d = 1'b1;
            end
        end else if (width_ack && width_valid_q) begin
            width_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            width_q         <= '0;
            qual_q          <= 1'b0;
            event_pulse_q   <= 1'b0;
            event_count_q   <= '0;
            last_width_q    <= '0;
            width_valid_q   <= 1'b0;
            width_overrun_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            width_q         <= width_d;
            qual_q          <= qual_d;
            event_pulse_q   <= event_pulse_d;
            event_count_q   <= event_count_d;
            last_width_q    <= last_width_d;
            width_valid_q   <= width_valid_d;
            width_overrun_q <= width_overrun_d;
        end
    end

    assign sensor_level  = level;
    assign event_pulse   = event_pulse_q;
    assign event_count   = event_count_q;
    assign last_width    = last_width_q;
    assign width_valid   = width_valid_q;
    assign width_overrun = width_overrun_q;

endmodule

// File: tb/tb_sensor_reader.sv
// Purpose: self-checking bench for sensor_reader against a pulse-level reference model.
// Latency: n/a.
// Backpressure: drives width_ack directly, including same-cycle ack/latch.
module tb_sensor_reader;

    localparam int TW   = 24;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          sensor_in = 1'b0;
    logic          arm = 1'b0;
    logic          clear_count = 1'b0;
    logic [TW-1:0] debounce_cycles = '0;
    logic [TW-1:0] min_width = '0;
    logic          sensor_level;
    logic          event_pulse;
    logic [CW-1:0] event_count;
    logic [TW-1:0] last_width;
    logic          width_valid;
    logic          width_ack = 1'b0;
    logic          width_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (pulse-level view).
    int m_count, m_last, m_db, m_min;
    bit m_valid, m_over;

    // Event strobe monitor.
    int ev_cnt = 0;
    int ev_double = 0;
    bit ev_prev = 1'b0;

    sensor_reader #(.SYNC_STAGES(2), .TIME_W(TW), .COUNT_W(CW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .sensor_in       (sensor_in),
        .arm             (arm),
        .clear_count     (clear_count),
        .debounce_cycles (debounce_cycles),
        .min_width       (min_width),
        .sensor_level    (sensor_level),
        .event_pulse     (event_pulse),
        .event_count     (event_count),
        .last_width      (last_width),
        .width_valid     (width_valid),
        .width_ack       (width_ack),
        .width_overrun   (width_overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (event_pulse) ev_cnt++;
        if (event_pulse && ev_prev) ev_double++;
        ev_prev = event_pulse;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sensor_in = 1'b0; arm = 1'b0; clear_count = 1'b0; width_ack = 1'b0;
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        m_count = 0; m_last = 0; m_valid = 1'b0; m_over = 1'b0;
    endtask

    task automatic configure(input int db, input int mw);
        arm = 1'b0;
        tick(1);
        debounce_cycles = TW'(db);
        min_width = TW'(mw);
        m_db = db; m_min = mw;
        arm = 1'b1;
        tick(3);
    endtask

    // Model of one isolated raw pulse of L cycles; returns 1 if it should qualify.
    function automatic bit model_pulse(input int L);
        int lvl;
        int thr;
        lvl = (L >= m_db + 1) ? L : 0;
        thr = (m_min < 1) ? 1 : m_min;
        if (lvl >= thr + 1) begin
            m_count = (m_count == CMAX) ? CMAX : m_count + 1;
            if (m_valid) m_over = 1'b1;
            m_valid = 1'b1;
            m_last = lvl;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic run_pulse(input int L, input int G);
        sensor_in = 1'b1;
        tick(L);
        sensor_in = 1'b0;
        tick(G);
    endtask

    task automatic wait_level(input logic val, input string tag);
        for (int i = 0; i < 300; i++) begin
            if (sensor_level === val) break;
            tick(1);
        end
        n_checks++;
        if (sensor_level !== val) begin
            n_fail++;
            $display("FAIL %s: sensor_level timeout, got %b want %b", tag, sensor_level, val);
        end
    endtask

    task automatic test_reset();
        sensor_in = 1'b1; arm = 1'b1;
        reset_n = 1'b0;
        tick(3);
        n_checks++;
        if ({sensor_level, event_pulse, event_count, last_width, width_valid, width_overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset: outputs lvl=%b ev=%b cnt=%0d lw=%0d v=%b ov=%b, want all 0",
                     sensor_level, event_pulse, event_count, last_width, width_valid, width_overrun);
        end
        do_reset();
    endtask

    task automatic test_glitch();
        bit rose;
        do_reset();
        configure(3, 10);
        rose = 1'b0;
        sensor_in = 1'b1;
        for (int i = 0; i < 3; i++) begin tick(1); if (sensor_level) rose = 1'b1; end
        sensor_in = 1'b0;
        for (int i = 0; i < 15; i++) begin tick(1); if (sensor_level) rose = 1'b1; end
        n_checks++;
        if (rose) begin n_fail++; $display("FAIL glitch_level: sensor_level rose, want stay 0"); end
        n_checks++;
        if (event_count !== 0) begin n_fail++; $display("FAIL glitch_count: got %0d want 0", event_count); end
    endtask

    task automatic test_basic_pulse();
        int ev0;
        do_reset();
        configure(3, 10);
        ev0 = ev_cnt;
        void'(model_pulse(50));
        run_pulse(50, 20);
        n_checks++;
        if (ev_cnt - ev0 !== 1) begin n_fail++; $display("FAIL basic_events: got %0d want 1", ev_cnt - ev0); end
        n_checks++;
        if (event_count !== CW'(m_count)) begin n_fail++; $display("FAIL basic_count: got %0d want %0d", event_count, m_count); end
        n_checks++;
        if (last_width !== TW'(m_last)) begin n_fail++; $display("FAIL basic_width: got %0d want %0d", last_width, m_last); end
        n_checks++;
        if (width_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", width_valid); end
        width_ack = 1'b1; tick(1); width_ack = 1'b0; tick(1);
        n_checks++;
        if (width_valid !== 1'b0) begin n_fail++; $display("FAIL basic_ack: valid got %b want 0", width_valid); end
        // An ack with nothing pending is ignored.
        width_ack = 1'b1; tick(1); width_ack = 1'b0; tick(1);
        n_checks++;
        if ({width_valid, width_overrun} !== 2'b00) begin n_fail++; $display("FAIL idle_ack: v/ov got %b%b want 00", width_valid, width_overrun); end
    endtask

    task automatic test_min_width();
        int ev0;
        do_reset();
        configure(3, 100);
        ev0 = ev_cnt;
        void'(model_pulse(40));
        run_pulse(40, 20);
        n_checks++;
        if (ev_cnt - ev0 !== 0 || width_valid !== 1'b0) begin
            n_fail++; $display("FAIL short_pulse: events %0d valid %b, want 0 0", ev_cnt - ev0, width_valid);
        end
        void'(model_pulse(120));
        run_pulse(120, 20);
        n_checks++;
        if (event_count !== CW'(m_count) || last_width !== TW'(m_last)) begin
            n_fail++; $display("FAIL long_pulse: cnt %0d lw %0d, want %0d %0d", event_count, last_width, m_count, m_last);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        configure(3, 10);
        void'(model_pulse(30)); run_pulse(30, 20);
        void'(model_pulse(60)); run_pulse(60, 20);
        n_checks++;
        if ({width_valid, width_overrun} !== {m_valid, m_over} || last_width !== TW'(m_last)) begin
            n_fail++; $display("FAIL overrun: v=%b ov=%b lw=%0d, want %b %b %0d",
                               width_valid, width_overrun, last_width, m_valid, m_over, m_last);
        end
        // Ack lands on the same edge as the next latch (the edge after the level falls).
        sensor_in = 1'b1; tick(40); sensor_in = 1'b0;
        wait_level(1'b0, "ack_latch_wait");
        width_ack = 1'b1; tick(1); width_ack = 1'b0;
        tick(10);
        n_checks++;
        if (width_valid !== 1'b1 || last_width !== TW'(40)) begin
            n_fail++; $display("FAIL ack_same_cycle: v=%b lw=%0d, want 1 40", width_valid, last_width);
        end
    endtask

    task automatic test_arm();
        int ev0;
        do_reset();
        debounce_cycles = TW'(3); min_width = TW'(10); m_db = 3; m_min = 10;
        sensor_in = 1'b1;
        tick(20);
        ev0 = ev_cnt;
        arm = 1'b1;
        tick(40);
        n_checks++;
        if (ev_cnt - ev0 !== 0 || event_count !== 0) begin
            n_fail++; $display("FAIL stuck_high: events %0d cnt %0d, want 0 0", ev_cnt - ev0, event_count);
        end
        sensor_in = 1'b0; tick(15);
        void'(model_pulse(30)); run_pulse(30, 20);
        n_checks++;
        if (event_count !== CW'(m_count) || last_width !== TW'(m_last)) begin
            n_fail++; $display("FAIL after_low: cnt %0d lw %0d, want %0d %0d", event_count, last_width, m_count, m_last);
        end
        configure(3, 50);
        ev0 = ev_cnt;
        sensor_in = 1'b1; tick(30);
        arm = 1'b0; tick(40);
        sensor_in = 1'b0; tick(20);
        arm = 1'b1; tick(5);
        n_checks++;
        if (ev_cnt - ev0 !== 0 || event_count !== CW'(m_count) || last_width !== TW'(m_last)) begin
            n_fail++; $display("FAIL disarm: events %0d cnt %0d lw %0d, want 0 %0d %0d",
                               ev_cnt - ev0, event_count, last_width, m_count, m_last);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        configure(0, 1);
        for (int i = 0; i < CMAX + 1; i++) begin
            void'(model_pulse(4));
            run_pulse(4, 8);
        end
        n_checks++;
        if (event_count !== CW'(CMAX) || m_count != CMAX) begin
            n_fail++; $display("FAIL saturate: cnt %0d, want %0d", event_count, CMAX);
        end
        clear_count = 1'b1; tick(1); clear_count = 1'b0; tick(1);
        m_count = 0;
        n_checks++;
        if (event_count !== 0) begin n_fail++; $display("FAIL clear: cnt %0d want 0", event_count); end
        for (int i = 0; i < 5; i++) begin void'(model_pulse(4)); run_pulse(4, 8); end
        // Clear on the qualifying edge: first measuring cycle, two edges after level rises.
        sensor_in = 1'b1;
        wait_level(1'b1, "clear_qual_wait");
        tick(1); clear_count = 1'b1; tick(1); clear_count = 1'b0;
        n_checks++;
        if (event_count !== 1 || event_pulse !== 1'b1) begin
            n_fail++; $display("FAIL clear_and_qual: cnt %0d ev %b, want 1 1", event_count, event_pulse);
        end
        // Reset in the middle of a qualified pulse.
        tick(20);
        reset_n = 1'b0;
        tick(1);
        n_checks++;
        if ({sensor_level, event_pulse, event_count, last_width, width_valid, width_overrun} !== '0) begin
            n_fail++; $display("FAIL midpulse_reset: lvl=%b ev=%b cnt=%0d lw=%0d v=%b ov=%b, want all 0",
                               sensor_level, event_pulse, event_count, last_width, width_valid, width_overrun);
        end
        do_reset();
    endtask

    task automatic test_random();
        int ev0, L, G;
        bit q;
        do_reset();
        configure($urandom_range(0, 4), $urandom_range(0, 40));
        for (int i = 0; i < 40; i++) begin
            if (i % 10 == 0) configure($urandom_range(0, 4), $urandom_range(0, 40));
            L = $urandom_range(1, 60);
            G = m_db + 8 + $urandom_range(0, 5);
            ev0 = ev_cnt;
            q = model_pulse(L);
            run_pulse(L, G);
            n_checks++;
            if (ev_cnt - ev0 !== int'(q) || event_count !== CW'(m_count) || width_valid !== m_valid
                || width_overrun !== m_over || last_width !== TW'(m_last)) begin
                n_fail++;
                $display("FAIL random[%0d] L=%0d db=%0d min=%0d: ev %0d cnt %0d v %b ov %b lw %0d, want %0d %0d %b %b %0d",
                         i, L, m_db, m_min, ev_cnt - ev0, event_count, width_valid, width_overrun, last_width,
                         q, m_count, m_valid, m_over, m_last);
            end
            if ($urandom_range(0, 2) == 0) begin
                width_ack = 1'b1; tick(1); width_ack = 1'b0;
                m_valid = 1'b0;
            end
        end
        n_checks++;
        if (ev_double !== 0) begin n_fail++; $display("FAIL strobe_width: %0d multi-cycle strobes, want 0", ev_double); end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_basic_pulse();
        test_min_width();
        test_overrun();
        test_arm();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
